// File: rtl/slot_seq_pkg.sv
// ---------------------------------------------------------------------------
// slot_seq_pkg
// Shared constants and helpers for the slot chain sequencer.
//   - FSM state encoding (IDLE, CLEAR, RUN, DONE, TIMEOUT)
//   - role-bit indices used when building the per-slot role vectors
//   - width helpers derived from the slot count / cycle counts
//   - role_of(): role bits of one slot for a given chain length
// The TIMEOUT state is only reachable when SLOT_SEQ_STEP_TIMEOUT_EN is
// defined in the sequencer build.
// ---------------------------------------------------------------------------
package slot_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR   = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN     = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_TIMEOUT = 3'd4;

  // Bit positions inside a per-slot role vector.
  localparam int ROLE_INICIO     = 0;
  localparam int ROLE_INTERMEDIO = 1;
  localparam int ROLE_FINAL      = 2;
  localparam int N_ROLES         = 3;

  // Width of the LEN input: must hold 0..n_slots.
  function automatic int len_width(input int n_slots);
    return $clog2(n_slots + 1);
  endfunction

  // Width of the STEP output: must hold 0..n_slots-1.
  function automatic int step_width(input int n_slots);
    return (n_slots < 2) ? 1 : $clog2(n_slots);
  endfunction

  // Width of a down/up counter that must hold 0..n_cycles-1.
  function automatic int count_width(input int n_cycles);
    return (n_cycles <= 2) ? 1 : $clog2(n_cycles);
  endfunction

  // Role bits of slot idx in a chain of len slots. Slots beyond the chain
  // get no role at all; a one-slot chain is both first and last.
  function automatic logic [N_ROLES-1:0] role_of(input int idx, input int len);
    logic [N_ROLES-1:0] r;
    r = '0;
    if (idx < len) begin
      r[ROLE_INICIO]     = (idx == 0);
      r[ROLE_FINAL]      = (idx == len - 1);
      r[ROLE_INTERMEDIO] = !r[ROLE_INICIO] && !r[ROLE_FINAL];
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_rise_detect.sv
// ---------------------------------------------------------------------------
// slot_rise_detect
// Registered rising-edge detector for the slot Q vector.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low clear
//   q      in   WIDTH  raw slot Q outputs
//   rise   out  WIDTH  one-cycle pulse per bit, one clock after that bit was
//                      first sampled high
// The rise vector is registered so that a Q bit first sampled high at edge t
// is acted on by the sequencer at edge t+1.
// ---------------------------------------------------------------------------
module slot_rise_detect
  import slot_seq_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] q_d_reg;
  logic [WIDTH-1:0] rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_d_reg  <= '0;
      rise_reg <= '0;
    end else begin
      q_d_reg  <= q;
      // High only for the first sample of a level: a held Q gives one pulse.
      rise_reg <= q & ~q_d_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/slot_chain_sequencer.sv
// ---------------------------------------------------------------------------
// slot_chain_sequencer
// Controller for a chain of up to N_SLOTS slot cells: assigns static roles,
// pulses the shared slot reset, then walks a one-hot ACTIVE token from slot 0
// to slot LEN-1, advancing when the active slot's Q rises.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   START       in   level, starts a run from IDLE/DONE/TIMEOUT if LEN valid
//   ABORT       in   level, highest priority, returns to IDLE
//   LEN         in   number of slots used (1..N_SLOTS), latched at START
//   SLOT_Q      in   Q outputs of the slots
//   INICIO      out  role bit: first slot of the chain
//   INTERMEDIO  out  role bit: middle slots
//   FINAL       out  role bit: last slot of the chain
//   SLOT_RESET  out  clear pulse, CLR_CYCLES long, while in CLEAR
//   ACTIVE      out  one-hot current step, zero outside RUN
//   STEP        out  index of the current step
//   BUSY        out  high in CLEAR and RUN
//   DONE        out  high in DONE
//   TIMEOUT     out  high in TIMEOUT (constant 0 without the watchdog)
//
// Build option: define SLOT_SEQ_STEP_TIMEOUT_EN to add a per-step watchdog
// of TIMEOUT_CYCLES clocks and the TIMEOUT state.
// ---------------------------------------------------------------------------
module slot_chain_sequencer
  import slot_seq_pkg::*;
#(
  parameter int N_SLOTS        = 9,
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           START,
  input  logic                           ABORT,
  input  logic [len_width(N_SLOTS)-1:0]  LEN,
  input  logic [N_SLOTS-1:0]             SLOT_Q,
  output logic [N_SLOTS-1:0]             INICIO,
  output logic [N_SLOTS-1:0]             INTERMEDIO,
  output logic [N_SLOTS-1:0]             FINAL,
  output logic                           SLOT_RESET,
  output logic [N_SLOTS-1:0]             ACTIVE,
  output logic [step_width(N_SLOTS)-1:0] STEP,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           TIMEOUT
);

  localparam int LEN_W  = len_width(N_SLOTS);
  localparam int STEP_W = step_width(N_SLOTS);
  localparam int CLR_W  = count_width(CLR_CYCLES);

  localparam logic [LEN_W-1:0]   LEN_MAX      = LEN_W'(N_SLOTS);
  localparam logic [CLR_W-1:0]   CLR_INIT     = CLR_W'(CLR_CYCLES - 1);
  localparam logic [N_SLOTS-1:0] FIRST_ACTIVE = N_SLOTS'(1);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [STEP_W-1:0]  step_reg, step_next;
  logic [N_SLOTS-1:0] active_reg, active_next;
  logic [CLR_W-1:0]   clr_cnt_reg, clr_cnt_next;

  logic [N_SLOTS-1:0] inicio_reg, intermedio_reg, final_reg;
  logic [N_SLOTS-1:0] inicio_next, intermedio_next, final_next;

  logic [N_SLOTS-1:0] rise;
  logic               start_ok;
  logic               advance;
  logic               last_step;

`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
  localparam int            TO_W    = count_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
`else
  // Watchdog limit has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // -------------------------------------------------------------------------
  // Edge detection on the slot outputs
  // -------------------------------------------------------------------------
  slot_rise_detect #(
    .WIDTH (N_SLOTS)
  ) u_rise (
    .clk   (CLK),
    .rst_n (RESET_N),
    .q     (SLOT_Q),
    .rise  (rise)
  );

  assign start_ok = START && (LEN != '0) && (LEN <= LEN_MAX);

  // ACTIVE is one-hot at STEP, so masking the rise vector with it selects
  // the rise of the current slot without a variable index.
  assign advance = |(rise & active_reg);

  assign last_step = (LEN_W'(step_reg) == (len_reg - LEN_W'(1)));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    step_next    = step_reg;
    active_next  = active_reg;
    clr_cnt_next = clr_cnt_reg;
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
    to_cnt_next  = to_cnt_reg;
`endif

    if (ABORT) begin
      state_next  = ST_IDLE;
      active_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_next   = ST_CLEAR;
            len_next     = LEN;
            clr_cnt_next = CLR_INIT;
            active_next  = '0;
          end
        end

`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
        ST_TIMEOUT: begin
          if (start_ok) begin
            state_next   = ST_CLEAR;
            len_next     = LEN;
            clr_cnt_next = CLR_INIT;
            active_next  = '0;
          end
        end
`endif

        ST_CLEAR: begin
          if (clr_cnt_reg == '0) begin
            state_next  = ST_RUN;
            step_next   = '0;
            active_next = FIRST_ACTIVE;
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
            to_cnt_next = '0;
`endif
          end else begin
            clr_cnt_next = clr_cnt_reg - CLR_W'(1);
          end
        end

        ST_RUN: begin
          if (advance) begin
            if (last_step) begin
              // STEP keeps the last index so the display can show it.
              state_next  = ST_DONE;
              active_next = '0;
            end else begin
              step_next   = step_reg + STEP_W'(1);
              active_next = active_reg << 1;
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
              to_cnt_next = '0;
`endif
            end
          end
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
          // An advance in the expiry cycle takes precedence over the watchdog.
          else if (to_cnt_reg == TO_LAST) begin
            state_next  = ST_TIMEOUT;
            active_next = '0;
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
`endif
        end

        default: begin
          state_next  = ST_IDLE;
          active_next = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      step_reg    <= '0;
      active_reg  <= '0;
      clr_cnt_reg <= '0;
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
      to_cnt_reg  <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      step_reg    <= step_next;
      active_reg  <= active_next;
      clr_cnt_reg <= clr_cnt_next;
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
      to_cnt_reg  <= to_cnt_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Role bits: re-derived from the latched length every cycle, so they change
  // one clock after a latch and stay put until the next one.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_role
    logic [N_ROLES-1:0] role_bits;
    assign role_bits           = role_of(gi, int'(len_reg));
    assign inicio_next[gi]     = role_bits[ROLE_INICIO];
    assign intermedio_next[gi] = role_bits[ROLE_INTERMEDIO];
    assign final_next[gi]      = role_bits[ROLE_FINAL];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inicio_reg     <= '0;
      intermedio_reg <= '0;
      final_reg      <= '0;
    end else begin
      inicio_reg     <= inicio_next;
      intermedio_reg <= intermedio_next;
      final_reg      <= final_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign INICIO     = inicio_reg;
  assign INTERMEDIO = intermedio_reg;
  assign FINAL      = final_reg;
  assign ACTIVE     = active_reg;
  assign STEP       = step_reg;
  assign SLOT_RESET = (state_reg == ST_CLEAR);
  assign BUSY       = (state_reg == ST_CLEAR) || (state_reg == ST_RUN);
  assign DONE       = (state_reg == ST_DONE);
`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
  assign TIMEOUT    = (state_reg == ST_TIMEOUT);
`else
  assign TIMEOUT    = 1'b0;
`endif

endmodule

// File: tb/tb_slot_chain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_slot_chain_sequencer
// Self-checking bench for slot_chain_sequencer (N_SLOTS=9, CLR_CYCLES=4,
// TIMEOUT_CYCLES=10). Expected values come from the behaviour rules:
// token position 1<<k, role masks from chain length, pulse length counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slot_chain_sequencer;

  localparam int N   = 9;
  localparam int CLR = 4;
  localparam int TO  = 10;
  localparam int LW  = $clog2(N + 1);
  localparam int SW  = $clog2(N);

  logic          CLK     = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START   = 1'b0;
  logic          ABORT   = 1'b0;
  logic [LW-1:0] LEN     = '0;
  logic [N-1:0]  SLOT_Q  = '0;
  logic [N-1:0]  INICIO, INTERMEDIO, FINAL, ACTIVE;
  logic          SLOT_RESET, BUSY, DONE, TIMEOUT;
  logic [SW-1:0] STEP;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  slot_chain_sequencer #(
    .N_SLOTS        (N),
    .CLR_CYCLES     (CLR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .ABORT      (ABORT),
    .LEN        (LEN),
    .SLOT_Q     (SLOT_Q),
    .INICIO     (INICIO),
    .INTERMEDIO (INTERMEDIO),
    .FINAL      (FINAL),
    .SLOT_RESET (SLOT_RESET),
    .ACTIVE     (ACTIVE),
    .STEP       (STEP),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .TIMEOUT    (TIMEOUT)
  );

  // Absolute bound on the run time.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench time limit reached");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Role masks straight from the chain-length rules.
  function automatic logic [31:0] mask_first(input int l);
    return (l >= 1) ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] mask_last(input int l);
    return (l >= 1) ? (32'd1 << (l - 1)) : 32'd0;
  endfunction
  function automatic logic [31:0] mask_mid(input int l);
    return ((32'd1 << l) - 32'd1) & ~mask_first(l) & ~mask_last(l);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".active"}, 32'(ACTIVE), 32'd0);
    check({tag, ".slot_reset"}, 32'(SLOT_RESET), 32'd0);
    check({tag, ".busy"}, 32'(BUSY), 32'd0);
    check({tag, ".done"}, 32'(DONE), 32'd0);
    check({tag, ".timeout"}, 32'(TIMEOUT), 32'd0);
  endtask

  task automatic check_roles(input string tag, input int l);
    check({tag, ".inicio"}, 32'(INICIO), mask_first(l));
    check({tag, ".intermedio"}, 32'(INTERMEDIO), mask_mid(l));
    check({tag, ".final"}, 32'(FINAL), mask_last(l));
  endtask

  // START with length l, then measure the clear pulse and the RUN entry.
  task automatic start_run(input int l);
    int n;
    SLOT_Q = '0;
    LEN    = LW'(l);
    START  = 1'b1;
    tick();
    START  = 1'b0;
    LEN    = LW'($urandom_range(0, 15));   // must not matter after the latch
    n = 0;
    while (SLOT_RESET === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    check("clear_len", 32'(n), 32'(CLR));
    check("run_entry.active", 32'(ACTIVE), 32'd1);
    check("run_entry.step", 32'(STEP), 32'd0);
    check("run_entry.busy", 32'(BUSY), 32'd1);
    check_roles("roles", l);
    $display("start len=%0d clear_cycles=%0d", l, n);
  endtask

  // Walk the token through all l steps with random idle gaps and noise on
  // the non-active slots.
  task automatic run_steps(input int l);
    logic [N-1:0] noise;
    int d;
    for (int k = 0; k < l; k++) begin
      SLOT_Q[k] = 1'b0;
      d = $urandom_range(1, 4);
      for (int g = 0; g < d; g++) begin
        noise    = N'($urandom);
        noise[k] = 1'b0;
        SLOT_Q   = noise;
        tick();
        check("gap.active", 32'(ACTIVE), 32'd1 << k);
        check("gap.step", 32'(STEP), 32'(k));
      end
      SLOT_Q[k] = 1'b1;
      tick();
      check("latency.active", 32'(ACTIVE), 32'd1 << k);
      tick();
      if (k < l - 1) begin
        check("adv.active", 32'(ACTIVE), 32'd1 << (k + 1));
        check("adv.step", 32'(STEP), 32'(k + 1));
      end else begin
        check("done.done", 32'(DONE), 32'd1);
        check("done.busy", 32'(BUSY), 32'd0);
        check("done.active", 32'(ACTIVE), 32'd0);
        check("done.step", 32'(STEP), 32'(l - 1));
      end
    end
    $display("run len=%0d walked to done", l);
  endtask

  initial begin
    int l;

    // ---- reset ----
    #12;
    check("rst.inicio", 32'(INICIO), 32'd0);
    check("rst.intermedio", 32'(INTERMEDIO), 32'd0);
    check("rst.final", 32'(FINAL), 32'd0);
    check("rst.step", 32'(STEP), 32'd0);
    check_quiet("rst");
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    $display("reset released");

    // ---- invalid lengths are ignored ----
    for (int i = 0; i < 3; i++) begin
      l = (i == 0) ? 0 : ((i == 1) ? N + 1 : 15);
      LEN = LW'(l);
      START = 1'b1;
      tick();
      tick();
      START = 1'b0;
      check_quiet("bad_len");
      check_roles("bad_len.roles", 0);
      $display("start len=%0d ignored", l);
    end

    // ---- ABORT beats START in IDLE ----
    LEN = LW'(3); START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    check_quiet("abort_prio");
    $display("abort with start held in idle");

    // ---- directed LEN=3 walk ----
    start_run(3);
    run_steps(3);

    // ---- invalid START from DONE keeps DONE ----
    LEN = '0; START = 1'b1;
    tick();
    START = 1'b0;
    check("done_bad_start", 32'(DONE), 32'd1);

    // ---- LEN=1 from DONE ----
    start_run(1);
    run_steps(1);

    // ---- non-active rise ignored, held Q advances once, abort in RUN ----
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    start_run(5);
    SLOT_Q[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ignore.active", 32'(ACTIVE), 32'd1);
    end
    SLOT_Q[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.active", 32'(ACTIVE), (i == 0) ? 32'd1 : 32'd2);
    end
    check("hold.step", 32'(STEP), 32'd1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check_quiet("abort_run");
    $display("abort at step 1");

    // ---- abort during CLEAR cycle 2 ----
    SLOT_Q = '0; LEN = LW'(4); START = 1'b1;
    tick();
    START = 1'b0;
    check("clr_c1.slot_reset", 32'(SLOT_RESET), 32'd1);
    tick();
    check("clr_c2.slot_reset", 32'(SLOT_RESET), 32'd1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check_quiet("abort_clear");
    repeat (6) tick();
    check_quiet("abort_clear.later");
    $display("abort in clear cycle 2");

    // ---- randomized runs ----
    for (int r = 0; r < 8; r++) begin
      l = $urandom_range(1, N);
      start_run(l);
      run_steps(l);
      if ($urandom_range(0, 1) == 1) begin
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_quiet("abort_done");
        $display("abort from done");
      end
    end

`ifdef SLOT_SEQ_STEP_TIMEOUT_EN
    // ---- watchdog expiry ----
    start_run(3);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("to_wait.active", 32'(ACTIVE), 32'd1);
      check("to_wait.timeout", 32'(TIMEOUT), 32'd0);
    end
    tick();
    check("to.timeout", 32'(TIMEOUT), 32'd1);
    check("to.active", 32'(ACTIVE), 32'd0);
    check("to.busy", 32'(BUSY), 32'd0);
    $display("step watchdog expired");
    // START from TIMEOUT, then rise seen in the last watchdog cycle
    start_run(2);
    repeat (TO - 2) tick();
    SLOT_Q[0] = 1'b1;
    tick();
    check("to_edge.active", 32'(ACTIVE), 32'd1);
    tick();
    check("to_edge.adv", 32'(ACTIVE), 32'd2);
    check("to_edge.timeout", 32'(TIMEOUT), 32'd0);
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    $display("advance beats watchdog");
`else
    // ---- no watchdog: RUN waits indefinitely ----
    start_run(2);
    repeat (3 * TO) tick();
    check("no_to.active", 32'(ACTIVE), 32'd1);
    check("no_to.busy", 32'(BUSY), 32'd1);
    check("no_to.timeout", 32'(TIMEOUT), 32'd0);
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    $display("long wait in run without watchdog");
`endif

    // ---- async reset mid-run ----
    start_run(4);
    SLOT_Q[0] = 1'b1;
    tick();
    tick();
    check("pre_rst.active", 32'(ACTIVE), 32'd2);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst.inicio", 32'(INICIO), 32'd0);
    check("async_rst.intermedio", 32'(INTERMEDIO), 32'd0);
    check("async_rst.final", 32'(FINAL), 32'd0);
    check("async_rst.step", 32'(STEP), 32'd0);
    check_quiet("async_rst");
    @(negedge CLK);
    SLOT_Q  = '0;
    RESET_N = 1'b1;
    repeat (3) tick();
    check_quiet("post_rst");
    $display("async reset mid run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_chain_sequencer.md
Name: slot_chain_sequencer

Overview:
- Controller for a chain of up to N_SLOTS Slot cells.
- Assigns each slot its static role (INICIO / INTERMEDIO / FINAL) and pulses the shared slot RESET to clear the chain.
- Walks a one-hot ACTIVE token from slot 0 to slot LEN-1, advancing when the active slot's Q rises.
- Sits between the front-panel START/ABORT controls and the slot array; reports BUSY/DONE/STEP to LEDs and the display logic.

Parameters:
- N_SLOTS, 9, number of physical slots in the chain (2..16).
- CLR_CYCLES, 4, length of the SLOT_RESET pulse in clocks (>=1).
- TIMEOUT_CYCLES, 50000000, per-step watchdog limit; used only with STEP_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  level; sampled in IDLE/DONE/TIMEOUT, starts a run.
- ABORT  in  1  level; forces return to IDLE.
- LEN  in  clog2(N_SLOTS+1)  number of slots used in the run; latched at START.
- SLOT_Q  in  N_SLOTS  Q outputs of the slots.
- INICIO  out  N_SLOTS  role bits to the slots.
- INTERMEDIO  out  N_SLOTS  role bits to the slots.
- FINAL  out  N_SLOTS  role bits to the slots.
- SLOT_RESET  out  1  clear pulse to the slot RESET inputs.
- ACTIVE  out  N_SLOTS  one-hot current step; zero when not in RUN.
- STEP  out  clog2(N_SLOTS)  index of the current step.
- BUSY  out  1  high in CLEAR and RUN.
- DONE  out  1  high in DONE.
- TIMEOUT  out  1  high in TIMEOUT; tied 0 when the feature is off.

Behaviour:
- Reset: async on RESET_N=0. State=IDLE. All outputs 0. Latched len=0. Edge-detect register=0.
- States:
  - IDLE: START=1 and 1<=LEN<=N_SLOTS -> latch LEN -> CLEAR. LEN=0 or LEN>N_SLOTS -> START ignored, stay IDLE.
  - CLEAR: SLOT_RESET=1 for exactly CLR_CYCLES cycles, with a counter loaded at entry. Then RUN with STEP=0, ACTIVE=1.
  - RUN: rise = SLOT_Q & ~SLOT_Q_d, where SLOT_Q_d is registered every cycle.
    - rise[STEP]=1 and STEP<len-1: STEP+1 and ACTIVE<<1 on the next edge.
    - rise[STEP]=1 and STEP==len-1: -> DONE; ACTIVE=0, STEP holds its last value.
    - Rises on non-active bits are ignored. SLOT_Q held high does not re-advance.
  - DONE: DONE=1 until START (valid LEN -> CLEAR, re-latching LEN) or ABORT (-> IDLE).
- Latency: SLOT_Q[STEP] first sampled high at edge t -> ACTIVE/STEP updated at edge t+1.
- ABORT has priority over START, advance and timeout. ABORT=1 -> IDLE on the next edge; ACTIVE, SLOT_RESET, BUSY and DONE cleared.
- ABORT during CLEAR truncates the pulse.
- Roles: registered from latched len, updated the cycle after latch, held until the next latch. For i<len:
  - INICIO[i]=(i==0).
  - FINAL[i]=(i==len-1).
  - INTERMEDIO[i]=!INICIO[i]&&!FINAL[i].
  - len=1: slot 0 gets INICIO=1 and FINAL=1.
  - Slots i>=len: all three role bits 0.
- BUSY = state in {CLEAR, RUN}.
- RESET_N asserted mid-run: immediate return to IDLE with all outputs 0. No resume.

Optional Feature:
- Macro: SLOT_SEQ_STEP_TIMEOUT_EN.
- Defined:
  - A per-step counter clears on entering RUN and on each advance.
  - Counter reaching TIMEOUT_CYCLES-1 without the expected rise -> TIMEOUT state; TIMEOUT=1, ACTIVE=0.
  - Exits via START (valid LEN) -> CLEAR, or ABORT -> IDLE.
  - If a rise and expiry occur in the same cycle, the advance wins.
- Undefined: no counter and no TIMEOUT state; TIMEOUT tied to 0.

Decomposition:
- Package slot_seq_pkg:
  - State encoding constants: IDLE=0, CLEAR=1, RUN=2, DONE=3, TIMEOUT=4.
  - Width constants derived from N_SLOTS.
  - Role-bit index constants.
- Sub-module slot_rise_detect: registered SLOT_Q_d plus the rise vector, N_SLOTS wide, with async active-low clear.

Test Plan:
- LEN=3, START pulse, CLR_CYCLES=4 -> SLOT_RESET high exactly 4 cycles. Then ACTIVE=001. INICIO=001, INTERMEDIO=010, FINAL=100.
- RUN with LEN=3; raise SLOT_Q[0], [1], [2] in turn -> ACTIVE 001->010->100, each one cycle after the rise. DONE=1 after SLOT_Q[2]; BUSY=0.
- In RUN at STEP=0, raise SLOT_Q[2] then hold SLOT_Q[0] high 5 cycles -> no advance on bit 2; exactly one advance to STEP=1.
- START with LEN=0 and with LEN=N_SLOTS+1 -> state stays IDLE, all outputs 0. LEN=1 -> slot 0 has INICIO=FINAL=1; one rise -> DONE.
- ABORT asserted during CLEAR cycle 2 and during RUN STEP=1 -> IDLE next edge, SLOT_RESET=0, ACTIVE=0. RESET_N low mid-RUN -> outputs 0 asynchronously.
- With SLOT_SEQ_STEP_TIMEOUT_EN and TIMEOUT_CYCLES=10: no rise -> TIMEOUT=1 after 10 RUN cycles. Rise in cycle 10 -> advance, no timeout. START from TIMEOUT -> CLEAR.
